// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: default widths and
// the requester-select encoding used for the round-robin history bit.
package reg_write_arbiter_pkg;

  localparam int W_DEF = 8;
  localparam int A_DEF = 3;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_sel_e;

endpackage

// File: rtl/reg_write_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. Ready outputs are combinational from Stall,
// both Valids and the registered last-grant history.
module rr_arb2
  import reg_write_arbiter_pkg::*;
(
  input  logic     Clk,
  input  logic     Reset,
  input  logic     Stall,
  input  logic     AValid,
  input  logic     BValid,
  output logic     AReady,
  output logic     BReady,
  output req_sel_e LastGrant
);

  req_sel_e last_q;
  req_sel_e last_d;
  logic     ready_a;
  logic     ready_b;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    ready_a = 1'b0;
    ready_b = 1'b0;
    last_d  = last_q;
    // Reset is folded in so nothing is offered while the block is held in reset.
    if (Reset && !Stall) begin
      if (AValid && BValid) begin
        if (last_q == REQ_A) ready_b = 1'b1;
        else                 ready_a = 1'b1;
      end else if (AValid) begin
        ready_a = 1'b1;
      end else if (BValid) begin
        ready_b = 1'b1;
      end
    end
    if (AValid && ready_a)      last_d = REQ_A;
    else if (BValid && ready_b) last_d = REQ_B;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) last_q <= REQ_B;  // history says B so A wins the first contest
    else        last_q <= last_d;
  end

  assign AReady    = ready_a;
  assign BReady    = ready_b;
  assign LastGrant = last_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates ALU and load writebacks onto a single register-file write port,
// with a one-cycle write stage and read-port bypass detection.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int A = A_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         AValid,
  input  logic [A-1:0] AAddr,
  input  logic [W-1:0] AData,
  output logic         AReady,
  input  logic         BValid,
  input  logic [A-1:0] BAddr,
  input  logic [W-1:0] BData,
  output logic         BReady,
  input  logic         Stall,
  output logic         RfWen,
  output logic [A-1:0] RfWaddr,
  output logic [W-1:0] RfWdata,
  input  logic [A-1:0] RaddrA,
  input  logic [A-1:0] RaddrB,
  output logic         FwdHitA,
  output logic         FwdHitB,
  output logic [W-1:0] FwdData,
  output logic         LastGrant
);

  req_sel_e last_grant;
  logic     grant_a;
  logic     grant_b;

  rr_arb2 u_arb (
    .Clk       (Clk),
    .Reset     (Reset),
    .Stall     (Stall),
    .AValid    (AValid),
    .BValid    (BValid),
    .AReady    (AReady),
    .BReady    (BReady),
    .LastGrant (last_grant)
  );

  assign grant_a = AValid & AReady;
  assign grant_b = BValid & BReady;

  // Write stage: Stall only gates new grants, so a loaded stage always writes.
  // NOTE: the whole stage is reset so a write captured before reset never escapes.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      RfWen   <= 1'b0;
      RfWaddr <= '0;
      RfWdata <= '0;
    end else begin
      RfWen <= grant_a | grant_b;
      if (grant_a) begin
        RfWaddr <= AAddr;
        RfWdata <= AData;
      end else if (grant_b) begin
        RfWaddr <= BAddr;
        RfWdata <= BData;
      end
    end
  end

  assign FwdHitA   = RfWen && (RfWaddr == RaddrA);
  assign FwdHitB   = RfWen && (RfWaddr == RaddrB);
  assign FwdData   = RfWdata;
  assign LastGrant = last_grant;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed, table-driven bench for reg_write_arbiter with hand-computed
// expectations plus hand-written stall and mid-operation reset sequences.
module tb_reg_write_arbiter;

  localparam int W = 8;
  localparam int A = 3;

  logic         Clk;
  logic         Reset;
  logic         AValid, BValid, Stall;
  logic [A-1:0] AAddr, BAddr, RaddrA, RaddrB;
  logic [W-1:0] AData, BData;
  logic         AReady, BReady, RfWen, FwdHitA, FwdHitB, LastGrant;
  logic [A-1:0] RfWaddr;
  logic [W-1:0] RfWdata, FwdData;

  reg_write_arbiter #(.W(W), .A(A)) dut (
    .Clk(Clk), .Reset(Reset),
    .AValid(AValid), .AAddr(AAddr), .AData(AData), .AReady(AReady),
    .BValid(BValid), .BAddr(BAddr), .BData(BData), .BReady(BReady),
    .Stall(Stall),
    .RfWen(RfWen), .RfWaddr(RfWaddr), .RfWdata(RfWdata),
    .RaddrA(RaddrA), .RaddrB(RaddrB),
    .FwdHitA(FwdHitA), .FwdHitB(FwdHitB), .FwdData(FwdData),
    .LastGrant(LastGrant)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Stand-in register file fed by the write port.
  logic [W-1:0] rf [8];
  always @(posedge Clk) if (RfWen) rf[RfWaddr] <= RfWdata;

  typedef struct {
    logic         stall, av;
    logic [A-1:0] aaddr;
    logic [W-1:0] adata;
    logic         bv;
    logic [A-1:0] baddr;
    logic [W-1:0] bdata;
    logic [A-1:0] ra, rb;
    logic         e_ar, e_br, e_wen;
    logic [A-1:0] e_waddr;
    logic [W-1:0] e_wdata;
    logic         e_fa, e_fb, e_last;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic av, input logic [A-1:0] aa, input logic [W-1:0] ad,
                       input logic bv, input logic [A-1:0] ba, input logic [W-1:0] bd,
                       input logic [A-1:0] ra, input logic [A-1:0] rb);
    Stall = s; AValid = av; AAddr = aa; AData = ad;
    BValid = bv; BAddr = ba; BData = bd; RaddrA = ra; RaddrB = rb;
  endtask

  initial begin
    //               stall av aa  ad    bv ba  bd    ra rb  ar br wen wa  wd    fa fb last
    vecs.push_back('{0, 1, 3, 8'h5A, 0, 0, 8'h00, 0, 0,  1, 0, 0, 0, 8'h00, 0, 0, 1}); // v0 A only
    vecs.push_back('{0, 0, 0, 8'h00, 0, 0, 8'h00, 3, 0,  0, 0, 1, 3, 8'h5A, 1, 0, 0}); // v1 write A
    vecs.push_back('{0, 0, 0, 8'h00, 1, 5, 8'hC3, 0, 0,  0, 1, 0, 3, 8'h5A, 0, 0, 0}); // v2 B only
    vecs.push_back('{0, 0, 0, 8'h00, 0, 0, 8'h00, 5, 4,  0, 0, 1, 5, 8'hC3, 1, 0, 1}); // v3 fwd hit A
    vecs.push_back('{0, 1, 1, 8'h11, 1, 2, 8'h22, 0, 0,  1, 0, 0, 5, 8'hC3, 0, 0, 1}); // v4 dual -> A
    vecs.push_back('{0, 1, 1, 8'h11, 1, 2, 8'h22, 2, 1,  0, 1, 1, 1, 8'h11, 0, 1, 0}); // v5 dual -> B
    vecs.push_back('{0, 1, 1, 8'h11, 1, 2, 8'h22, 0, 0,  1, 0, 1, 2, 8'h22, 0, 0, 1}); // v6 dual -> A
    vecs.push_back('{0, 1, 1, 8'h11, 1, 2, 8'h22, 0, 0,  0, 1, 1, 1, 8'h11, 0, 0, 0}); // v7 dual -> B
    vecs.push_back('{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 0, 1, 2, 8'h22, 0, 0, 1}); // v8
    vecs.push_back('{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 0, 0, 2, 8'h22, 0, 0, 1}); // v9 hold
    vecs.push_back('{0, 1, 6, 8'h01, 1, 6, 8'h02, 0, 0,  1, 0, 0, 2, 8'h22, 0, 0, 1}); // v10 same addr
    vecs.push_back('{0, 0, 0, 8'h00, 1, 6, 8'h02, 0, 0,  0, 1, 1, 6, 8'h01, 0, 0, 0}); // v11
    vecs.push_back('{0, 0, 0, 8'h00, 0, 0, 8'h00, 6, 6,  0, 0, 1, 6, 8'h02, 1, 1, 1}); // v12
    vecs.push_back('{0, 0, 0, 8'h00, 0, 0, 8'h00, 6, 6,  0, 0, 0, 6, 8'h02, 0, 0, 1}); // v13 wen gates fwd
    vecs.push_back('{1, 1, 4, 8'h44, 0, 0, 8'h00, 0, 0,  0, 0, 0, 6, 8'h02, 0, 0, 1}); // v14 stall
    vecs.push_back('{1, 1, 4, 8'h44, 0, 0, 8'h00, 0, 0,  0, 0, 0, 6, 8'h02, 0, 0, 1}); // v15 stall
    vecs.push_back('{1, 1, 4, 8'h44, 0, 0, 8'h00, 0, 0,  0, 0, 0, 6, 8'h02, 0, 0, 1}); // v16 stall
    vecs.push_back('{0, 1, 4, 8'h44, 0, 0, 8'h00, 0, 0,  1, 0, 0, 6, 8'h02, 0, 0, 1}); // v17 stall drops
    vecs.push_back('{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 0, 1, 4, 8'h44, 0, 0, 0}); // v18
    vecs.push_back('{1, 1, 1, 8'h10, 1, 2, 8'h20, 0, 0,  0, 0, 0, 4, 8'h44, 0, 0, 0}); // v19 stall dual
    vecs.push_back('{0, 1, 7, 8'h77, 0, 0, 8'h00, 0, 0,  1, 0, 0, 4, 8'h44, 0, 0, 0}); // v20
    vecs.push_back('{1, 0, 0, 8'h00, 1, 1, 8'h99, 0, 0,  0, 0, 1, 7, 8'h77, 0, 0, 0}); // v21 stall vs stage
    vecs.push_back('{0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 0, 0, 7, 8'h77, 0, 0, 0}); // v22

    Reset = 1'b0;
    drive(0, 1, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    repeat (2) @(posedge Clk);
    #2;
    check("rst AReady", AReady, 0);
    check("rst BReady", BReady, 0);
    check("rst RfWen", RfWen, 0);
    check("rst RfWaddr", RfWaddr, 0);
    check("rst RfWdata", RfWdata, 0);
    check("rst FwdHitA", FwdHitA, 0);
    check("rst FwdHitB", FwdHitB, 0);
    check("rst LastGrant", LastGrant, 1);
    drive(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    @(negedge Clk) Reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge Clk);
      #1;
      drive(vecs[i].stall, vecs[i].av, vecs[i].aaddr, vecs[i].adata,
            vecs[i].bv, vecs[i].baddr, vecs[i].bdata, vecs[i].ra, vecs[i].rb);
      #1;
      check($sformatf("v%0d AReady", i),    AReady,    vecs[i].e_ar);
      check($sformatf("v%0d BReady", i),    BReady,    vecs[i].e_br);
      check($sformatf("v%0d RfWen", i),     RfWen,     vecs[i].e_wen);
      check($sformatf("v%0d RfWaddr", i),   RfWaddr,   vecs[i].e_waddr);
      check($sformatf("v%0d RfWdata", i),   RfWdata,   vecs[i].e_wdata);
      check($sformatf("v%0d FwdData", i),   FwdData,   vecs[i].e_wdata);
      check($sformatf("v%0d FwdHitA", i),   FwdHitA,   vecs[i].e_fa);
      check($sformatf("v%0d FwdHitB", i),   FwdHitB,   vecs[i].e_fb);
      check($sformatf("v%0d LastGrant", i), LastGrant, vecs[i].e_last);
    end
    check("rf[6] after same-addr pair", rf[6], 8'h02);

    // Reset asserted while a granted write sits in the stage.
    @(posedge Clk);
    #1 drive(0, 1, 3, 8'h33, 0, 0, 8'h00, 0, 0);
    #1 check("mid grant AReady", AReady, 1);
    @(posedge Clk);
    #1 check("mid stage RfWen", RfWen, 1);
    Reset = 1'b0;
    #1;
    check("mid rst RfWen", RfWen, 0);
    check("mid rst RfWaddr", RfWaddr, 0);
    check("mid rst LastGrant", LastGrant, 1);
    check("mid rst AReady", AReady, 0);
    check("mid rst FwdHitA", FwdHitA, 0);
    AValid = 1'b0;
    @(negedge Clk) Reset = 1'b1;
    @(posedge Clk);
    #1 check("post rst RfWen", RfWen, 0);
    drive(0, 1, 2, 8'h09, 0, 0, 8'h00, 0, 0);
    #1 check("post rst AReady", AReady, 1);
    @(posedge Clk);
    #1;
    check("post rst write RfWen", RfWen, 1);
    check("post rst write RfWaddr", RfWaddr, 2);
    check("post rst write RfWdata", RfWdata, 8'h09);
    check("post rst LastGrant", LastGrant, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter W, default 8, data path width.
REQ-002 Parameter A, default 3, register address width (2**A registers).
REQ-003 Clk  input  1  sole clock; all state updates on posedge Clk.
REQ-004 Reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 AValid  input  1  requester A (ALU writeback) has a write pending.
REQ-006 AAddr  input  A  requester A destination register.
REQ-007 AData  input  W  requester A write data.
REQ-008 AReady  output  1  requester A write accepted this cycle when AValid also high.
REQ-009 BValid  input  1  requester B (memory load writeback) has a write pending.
REQ-010 BAddr  input  A  requester B destination register.
REQ-011 BData  input  W  requester B write data.
REQ-012 BReady  output  1  requester B write accepted this cycle when BValid also high.
REQ-013 Stall  input  1  blocks new acceptances while high.
REQ-014 RfWen  output  1  register-file write enable.
REQ-015 RfWaddr  output  A  register-file write address.
REQ-016 RfWdata  output  W  register-file write data.
REQ-017 RaddrA, RaddrB  input  A each  current register-file read addresses.
REQ-018 FwdHitA, FwdHitB  output  1 each  matching read port must take FwdData instead of register-file output.
REQ-019 FwdData  output  W  bypass value, equal to RfWdata.
REQ-020 LastGrant  output  1  0 = A granted most recently, 1 = B.

Function
REQ-021 Handshake: transfer on a requester occurs in a cycle where its Valid and Ready are both 1; Ready is combinational from Stall, both Valids and LastGrant.
REQ-022 Stall=1 forces AReady=BReady=0 regardless of Valid.
REQ-023 Only AValid=1 (Stall=0): AReady=1, BReady=0; only BValid=1: BReady=1, AReady=0.
REQ-024 Neither Valid: AReady=BReady=0, no grant.
REQ-025 Both Valid (Stall=0): grant the requester not named by LastGrant (round-robin); the loser's Ready=0 and it keeps Valid/Addr/Data stable.
REQ-026 On any grant, LastGrant updates to the granted requester at the next edge; without a grant it holds.
REQ-027 Both Valid to the same address: normal round-robin, no merging; both writes reach the register file in grant order.
REQ-028 Write stage: a grant in cycle N drives RfWen=1 with granted Addr/Data during cycle N+1 (latency exactly 1).
REQ-029 No grant in cycle N: RfWen=0 in cycle N+1; RfWaddr/RfWdata hold previous values.
REQ-030 Stall does not suppress an already-registered write; a stage loaded in cycle N always writes in N+1.
REQ-031 Back-to-back grants sustain one write per cycle (full throughput).
REQ-032 FwdHitA = RfWen AND (RfWaddr == RaddrA); FwdHitB likewise with RaddrB; both purely combinational.
REQ-033 FwdData = RfWdata at all times.
REQ-034 Steady alternation under continuous dual Valid: A, B, A, B, ... starting with A after reset.

Reset
REQ-035 Reset=0 asynchronously forces RfWen=0, RfWaddr=0, RfWdata=0, LastGrant=1 (A favoured first).
REQ-036 During reset AReady=BReady=0 and FwdHitA=FwdHitB=0.
REQ-037 Reset asserted mid-operation discards the registered write (no RfWen pulse after release); first grant possible in the first cycle after Reset returns to 1.

Structure
REQ-038 Shared package holds the W/A defaults and a requester-select enum (REQ_A=0, REQ_B=1) used for LastGrant.
REQ-039 One sub-module rr_arb2 (two-input round-robin grant logic with LastGrant state) is natural; write stage and forwarding stay in reg_write_arbiter.

Verification
REQ-040 Reset release, AValid=1 AAddr=3 AData=0x5A -> AReady=1, next cycle RfWen=1 RfWaddr=3 RfWdata=0x5A, LastGrant=0.
REQ-041 AValid=BValid=1 held 4 cycles, A addr 1 data 0x11, B addr 2 data 0x22 -> RfWaddr sequence 1,2,1,2, never two A grants in a row.
REQ-042 Stall=1 with AValid=1 for 3 cycles -> AReady=0 throughout, RfWen=0 from second stall cycle, write occurs one cycle after Stall drops.
REQ-043 Grant B addr 5 data 0xC3 while RaddrA=5 RaddrB=4 -> next cycle FwdHitA=1 FwdHitB=0 FwdData=0xC3.
REQ-044 Both Valid to addr 6 (A 0x01, B 0x02) -> two writes, A then B, final register 6 content 0x02.
REQ-045 Reset pulled low in the cycle after a grant -> RfWen=0 immediately, no write after release, LastGrant=1.
